button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 147 ++++++++++++++
 tb/tb_button_conditioner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Conditions the raw set/up buttons for the clock: synchronizes and debounces each button,
// produces the set level and press pulse, and turns a held up button into an auto-repeating pulse.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_PERIOD   = 100000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_set,
  input  logic i_btn_up,
  output logic o_set,
  output logic o_up,
  output logic o_set_pulse
);

  localparam int BTN_SET = 0;
  localparam int BTN_UP  = 1;

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_DELAY  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PERIOD = RPT_W'(REPEAT_PERIOD);
  localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } upState_e;

  logic [1:0]      syncMeta_q;
  logic [1:0]      syncOut_q;
  logic [1:0]      stable_q;
  logic [1:0]      stable_d;
  logic [DB_W-1:0] dbCnt_q [2];
  logic [DB_W-1:0] dbCnt_d [2];

  upState_e        upState_q;
  upState_e        upState_d;
  logic [RPT_W-1:0] rptCnt_q;
  logic [RPT_W-1:0] rptCnt_d;
  logic            upPulse_q;
  logic            upPulse_d;
  logic            setPulse_q;
  logic            setPulse_d;

  logic            upRise;
  logic            upFall;

  // A level is accepted once the synchronized input has disagreed with the stable value
  // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 2; i++) begin
      dbCnt_d[i] = '0;
      if (syncOut_q[i] != stable_q[i]) begin
        if (dbCnt_q[i] == DB_LAST) begin
          stable_d[i] = syncOut_q[i];
        end else begin
          dbCnt_d[i] = dbCnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign upRise     = stable_d[BTN_UP] & ~stable_q[BTN_UP];
  assign upFall     = ~stable_d[BTN_UP] & stable_q[BTN_UP];
  assign setPulse_d = stable_d[BTN_SET] & ~stable_q[BTN_SET];

  // Release wins over a repeat that falls due on the same cycle.
  always_comb begin
    upState_d = upState_q;
    rptCnt_d  = rptCnt_q;
    upPulse_d = 1'b0;
    case (upState_q)
      IDLE: begin
        if (upRise) begin
          upPulse_d = 1'b1;
          rptCnt_d  = RPT_ONE;
          upState_d = DELAY;
        end
      end
      DELAY: begin
        if (upFall) begin
          rptCnt_d  = '0;
          upState_d = IDLE;
        end else if (rptCnt_q == RPT_DELAY) begin
          upPulse_d = 1'b1;
          rptCnt_d  = RPT_ONE;
          upState_d = REPEAT;
        end else begin
          rptCnt_d = rptCnt_q + RPT_ONE;
        end
      end
      REPEAT: begin
        if (upFall) begin
          rptCnt_d  = '0;
          upState_d = IDLE;
        end else if (rptCnt_q == RPT_PERIOD) begin
          upPulse_d = 1'b1;
          rptCnt_d  = RPT_ONE;
        end else begin
          rptCnt_d = rptCnt_q + RPT_ONE;
        end
      end
      default: begin
        rptCnt_d  = '0;
        upState_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      syncMeta_q <= '0;
      syncOut_q  <= '0;
      stable_q   <= '0;
      for (int i = 0; i < 2; i++) begin
        dbCnt_q[i] <= '0;
      end
      upState_q  <= IDLE;
      rptCnt_q   <= '0;
      upPulse_q  <= 1'b0;
      setPulse_q <= 1'b0;
    end else begin
      syncMeta_q <= {i_btn_up, i_btn_set};
      syncOut_q  <= syncMeta_q;
      stable_q   <= stable_d;
      for (int i = 0; i < 2; i++) begin
        dbCnt_q[i] <= dbCnt_d[i];
      end
      upState_q  <= upState_d;
      rptCnt_q   <= rptCnt_d;
      upPulse_q  <= upPulse_d;
      setPulse_q <= setPulse_d;
    end
  end

  assign o_set       = stable_q[BTN_SET];
  assign o_up        = upPulse_q;
  assign o_set_pulse = setPulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: a directed vector table, hand-written corner
// sequences, then random button activity compared against a behavioural model.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int HL = DB + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btnSet = 1'b0;
  logic btnUp = 1'b0;
  logic oSet;
  logic oUp;
  logic oSetPulse;

  int checkCount = 0;
  int passCount = 0;

  typedef struct {
    logic rst;
    logic set;
    logic up;
    logic eSet;
    logic eUp;
    logic ePulse;
  } vec_t;

  vec_t vecs[$];

  // Model state: raw samples seen per edge (newest in bit 0), accepted levels, press time.
  logic [HL-1:0] hSet = '0;
  logic [HL-1:0] hUp = '0;
  logic mStableSet = 1'b0;
  logic mStableUp = 1'b0;
  logic mSet = 1'b0;
  logic mUp = 1'b0;
  logic mPulse = 1'b0;
  int edgeNum = 0;
  int pressT = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_btn_set(btnSet),
    .i_btn_up(btnUp),
    .o_set(oSet),
    .o_up(oUp),
    .o_set_pulse(oSetPulse)
  );

  always #5 clk = ~clk;

  // A level is accepted on edge m when the raw samples from edges m-1-DB .. m-2 all
  // show the opposite of the current accepted level.
  task automatic modelStep(input logic r, input logic s, input logic u);
    logic newSet;
    logic newUp;
    int d;
    edgeNum++;
    if (r) begin
      hSet = '0;
      hUp = '0;
      mStableSet = 1'b0;
      mStableUp = 1'b0;
      mSet = 1'b0;
      mUp = 1'b0;
      mPulse = 1'b0;
    end else begin
      hSet = {hSet[HL-2:0], s};
      hUp = {hUp[HL-2:0], u};
      newSet = (hSet[HL-1:2] == {DB{~mStableSet}}) ? ~mStableSet : mStableSet;
      newUp = (hUp[HL-1:2] == {DB{~mStableUp}}) ? ~mStableUp : mStableUp;
      mPulse = newSet & ~mStableSet;
      mUp = 1'b0;
      if (newUp && !mStableUp) begin
        mUp = 1'b1;
        pressT = edgeNum;
      end else if (newUp && mStableUp) begin
        d = edgeNum - pressT;
        mUp = (d == RD) || (d > RD && ((d - RD) % RP) == 0);
      end
      mStableSet = newSet;
      mStableUp = newUp;
      mSet = newSet;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic u);
    rst = r;
    btnSet = s;
    btnUp = u;
    @(posedge clk);
    modelStep(r, s, u);
    #1;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic eSet, input logic eUp, input logic ePulse);
    checkCount++;
    if ({oSet, oUp, oSetPulse} === {eSet, eUp, ePulse}) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s[%0d]: got set=%b up=%b setPulse=%b, expected set=%b up=%b setPulse=%b",
               name, idx, oSet, oUp, oSetPulse, eSet, eUp, ePulse);
    end
  endtask

  task automatic addVec(input logic r, input logic s, input logic u,
                        input logic eS, input logic eU, input logic eP, input int n);
    vec_t v;
    v.rst = r;
    v.set = s;
    v.up = u;
    v.eSet = eS;
    v.eUp = eU;
    v.ePulse = eP;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    int remSet;
    int remUp;
    logic curSet;
    logic curUp;
    logic r;

    // Both buttons pressed together right after reset, held, then released on edge 20.
    addVec(1, 0, 0, 0, 0, 0, 1);
    addVec(0, 1, 1, 0, 0, 0, 5);
    addVec(0, 1, 1, 1, 1, 1, 1);
    addVec(0, 1, 1, 1, 0, 0, 9);
    addVec(0, 1, 1, 1, 1, 0, 1);
    addVec(0, 1, 1, 1, 0, 0, 2);
    addVec(0, 1, 1, 1, 1, 0, 1);
    addVec(0, 0, 0, 1, 0, 0, 2);
    addVec(0, 0, 0, 1, 1, 0, 1);
    addVec(0, 0, 0, 1, 0, 0, 2);
    addVec(0, 0, 0, 0, 0, 0, 3);

    $display("[TB] directed table, %0d vectors", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].set, vecs[i].up);
      checkOutput("table", i, vecs[i].eSet, vecs[i].eUp, vecs[i].ePulse);
    end

    // Glitch shorter than the debounce window must leave everything quiet.
    applyStimulus(1, 0, 0);
    checkOutput("glitchReset", 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      applyStimulus(0, 0, (i < DB - 1) ? 1'b1 : 1'b0);
      checkOutput("glitch", i, 0, 0, 0);
    end

    // Bouncing up button, then a hold released so the fall lands on the first due repeat.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 0, ((i / 2) % 2 == 0) ? 1'b1 : 1'b0);
      checkOutput("bounce", i, 0, 0, 0);
    end
    for (int j = 0; j < 20; j++) begin
      applyStimulus(0, 0, (j < 10) ? 1'b1 : 1'b0);
      checkOutput("bounceHold", j, 0, (j == 5) ? 1'b1 : 1'b0, 0);
    end

    // Reset lands on a cycle where a repeat is due; the held button restarts as a fresh press.
    applyStimulus(1, 0, 0);
    checkOutput("rptReset", 0, 0, 0, 0);
    for (int j = 0; j < 18; j++) begin
      applyStimulus(0, 0, 1);
      checkOutput("rptHold", j, 0, (j == 5 || j == 15) ? 1'b1 : 1'b0, 0);
    end
    applyStimulus(1, 0, 1);
    checkOutput("rptMidReset", 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) begin
      applyStimulus(0, 0, 1);
      checkOutput("rptAfterReset", k, 0, (k == 5) ? 1'b1 : 1'b0, 0);
    end

    // Random activity against the model, mixing short bounces with long holds.
    curSet = 1'b0;
    curUp = btnUp;
    remSet = 0;
    remUp = 3;
    for (int i = 0; i < 4000; i++) begin
      if (remSet == 0) begin
        curSet = ~curSet;
        remSet = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(8, 60);
      end
      if (remUp == 0) begin
        curUp = ~curUp;
        remUp = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(8, 60);
      end
      remSet--;
      remUp--;
      r = ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0;
      applyStimulus(r, curSet, curUp);
      checkOutput("random", i, mSet, mUp, mPulse);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
